// File: rtl/display_pkg.sv
// Shared SVGA 800x600@60 raster constants, coordinate types and playfield bounds.
// Used by the timing generator, the renderer and the game logic.
package display_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W = 11;

  typedef logic [9:0]       pix_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Playfield margins inside the visible area.
  localparam pix_t PF_LEFT   = 10'd16;
  localparam pix_t PF_RIGHT  = 10'd783;
  localparam pix_t PF_TOP    = 10'd32;
  localparam pix_t PF_BOTTOM = 10'd583;

  function automatic cnt_t to_cnt(input int v);
    return cnt_t'(v);
  endfunction

endpackage

// File: rtl/vga_timing_generator_sync_counter.sv
// Generic raster counter: counts 0..PERIOD-1 while i_en, exposes the next count
// and its visible/sync window flags so the parent can register aligned outputs.
// Ports: i_clk, i_rst_n (sync, active-low), i_en; o_wrap, o_nxt, o_vis_nxt, o_sync_nxt.
module sync_counter
  import display_pkg::*;
#(
  parameter int PERIOD     = H_TOTAL,
  parameter int VIS_END    = H_VISIBLE,
  parameter int SYNC_START = H_VISIBLE + H_FRONT,
  parameter int SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_wrap,
  output cnt_t o_nxt,
  output logic o_vis_nxt,
  output logic o_sync_nxt
);

  localparam cnt_t C_LAST = to_cnt(PERIOD - 1);
  localparam cnt_t C_VIS  = to_cnt(VIS_END);
  localparam cnt_t C_SS   = to_cnt(SYNC_START);
  localparam cnt_t C_SE   = to_cnt(SYNC_END);

  cnt_t r_cnt;
  logic w_last;

  assign w_last     = (r_cnt == C_LAST);
  assign o_wrap     = i_en && w_last;
  assign o_nxt      = !i_en ? r_cnt
                    : w_last ? '0
                    : r_cnt + cnt_t'(1);
  assign o_vis_nxt  = (o_nxt < C_VIS);
  assign o_sync_nxt = (o_nxt >= C_SS) && (o_nxt < C_SE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= o_nxt;
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Free-running raster timing generator: syncs, pixel coordinate, visible flag,
// START_UPDATE pulse on entry to vertical blanking and a wrapping frame counter.
// Ports: CLK, RESET_N (sync, active-low), PIXEL_CE; HSYNC, VSYNC, VISIBLE,
// PIXEL_X, PIXEL_Y, START_UPDATE, FRAME_COUNT. All outputs are flops.
module vga_timing_generator
  import display_pkg::*;
#(
  parameter int H_VISIBLE        = display_pkg::H_VISIBLE,
  parameter int H_FRONT          = display_pkg::H_FRONT,
  parameter int H_SYNC           = display_pkg::H_SYNC,
  parameter int H_BACK           = display_pkg::H_BACK,
  parameter int V_VISIBLE        = display_pkg::V_VISIBLE,
  parameter int V_FRONT          = display_pkg::V_FRONT,
  parameter int V_SYNC           = display_pkg::V_SYNC,
  parameter int V_BACK           = display_pkg::V_BACK,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int FRAME_CNT_W      = 8
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   PIXEL_CE,
  output logic                   HSYNC,
  output logic                   VSYNC,
  output logic                   VISIBLE,
  output logic [9:0]             PIXEL_X,
  output logic [9:0]             PIXEL_Y,
  output logic                   START_UPDATE,
  output logic [FRAME_CNT_W-1:0] FRAME_COUNT
);

  localparam int   C_HT     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int   C_VT     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic C_S_ON   = (SYNC_ACTIVE_HIGH != 0);
  localparam logic C_S_OFF  = !C_S_ON;
  localparam cnt_t C_V_VIS  = to_cnt(V_VISIBLE);

  logic w_h_wrap, w_h_vis, w_h_sync;
  logic w_v_wrap_unused, w_v_vis, w_v_sync;
  cnt_t w_h_nxt, w_v_nxt;
  logic w_vis, w_frame;

  logic                   r_hsync, r_vsync, r_vis, r_su;
  pix_t                   r_x, r_y;
  logic [FRAME_CNT_W-1:0] r_fc;

  sync_counter #(
    .PERIOD     (C_HT),
    .VIS_END    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_en       (PIXEL_CE),
    .o_wrap     (w_h_wrap),
    .o_nxt      (w_h_nxt),
    .o_vis_nxt  (w_h_vis),
    .o_sync_nxt (w_h_sync)
  );

  sync_counter #(
    .PERIOD     (C_VT),
    .VIS_END    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_en       (w_h_wrap),
    .o_wrap     (w_v_wrap_unused),
    .o_nxt      (w_v_nxt),
    .o_vis_nxt  (w_v_vis),
    .o_sync_nxt (w_v_sync)
  );

  assign w_vis   = w_h_vis && w_v_vis;
  // v only moves on a line wrap, so this fires once: line V_VISIBLE-1 -> V_VISIBLE.
  assign w_frame = w_h_wrap && (w_v_nxt == C_V_VIS);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_hsync <= C_S_OFF;
      r_vsync <= C_S_OFF;
      r_vis   <= 1'b1;
      r_x     <= '0;
      r_y     <= '0;
      r_su    <= 1'b0;
      r_fc    <= '0;
    end else begin
      r_hsync <= w_h_sync ? C_S_ON : C_S_OFF;
      r_vsync <= w_v_sync ? C_S_ON : C_S_OFF;
      r_vis   <= w_vis;
      r_x     <= w_vis ? pix_t'(w_h_nxt) : '0;
      r_y     <= w_vis ? pix_t'(w_v_nxt) : '0;
      r_su    <= w_frame;
      if (w_frame) r_fc <= r_fc + FRAME_CNT_W'(1);
    end
  end

  assign HSYNC        = r_hsync;
  assign VSYNC        = r_vsync;
  assign VISIBLE      = r_vis;
  assign PIXEL_X      = r_x;
  assign PIXEL_Y      = r_y;
  assign START_UPDATE = r_su;
  assign FRAME_COUNT  = r_fc;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: full-size instance for line timing, small-parameter instance
// for vertical timing, START_UPDATE, FRAME_COUNT wrap, CE gating and reset.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ce;

  logic       f_hs, f_vs, f_vis, f_su;
  logic [9:0] f_x, f_y;
  logic [7:0] f_fc;

  logic       s_hs, s_vs, s_vis, s_su;
  logic [9:0] s_x, s_y;
  logic [1:0] s_fc;

  int checks = 0;
  int errors = 0;

  vga_timing_generator u_full (
    .CLK(clk), .RESET_N(rst_n), .PIXEL_CE(ce),
    .HSYNC(f_hs), .VSYNC(f_vs), .VISIBLE(f_vis),
    .PIXEL_X(f_x), .PIXEL_Y(f_y),
    .START_UPDATE(f_su), .FRAME_COUNT(f_fc)
  );

  // H_TOTAL=8 (hsync h 5..6), V_TOTAL=6 (vsync v 4), frame = 48 CE edges.
  vga_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(1), .FRAME_CNT_W(2)
  ) u_small (
    .CLK(clk), .RESET_N(rst_n), .PIXEL_CE(ce),
    .HSYNC(s_hs), .VSYNC(s_vs), .VISIBLE(s_vis),
    .PIXEL_X(s_x), .PIXEL_Y(s_y),
    .START_UPDATE(s_su), .FRAME_COUNT(s_fc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ce    = 1'b1;
    repeat (5) tick();
    checks++;
    if ({f_vis, f_hs, f_vs, f_su} !== 4'b1000 || f_x !== 10'd0
        || f_y !== 10'd0 || f_fc !== 8'd0) begin
      errors++;
      $display("FAIL reset_full vis=%b hs=%b vs=%b su=%b x=%0d y=%0d fc=%0d want 1 0 0 0 0 0 0",
               f_vis, f_hs, f_vs, f_su, f_x, f_y, f_fc);
    end
    checks++;
    if ({s_vis, s_hs, s_vs, s_su} !== 4'b1000 || s_x !== 10'd0
        || s_y !== 10'd0 || s_fc !== 2'd0) begin
      errors++;
      $display("FAIL reset_small vis=%b hs=%b vs=%b su=%b x=%0d y=%0d fc=%0d want 1 0 0 0 0 0 0",
               s_vis, s_hs, s_vs, s_su, s_x, s_y, s_fc);
    end
  endtask

  task automatic test_hline;
    int rise1, rise2, fall1;
    logic prev, bad;
    rise1 = -1; rise2 = -1; fall1 = -1;
    prev = 1'b0; bad = 1'b0;
    rst_n = 1'b1;
    ce    = 1'b1;
    for (int e = 1; e <= 2112; e++) begin
      tick();
      if (f_hs && !prev) begin
        if (rise1 < 0) rise1 = e;
        else if (rise2 < 0) rise2 = e;
      end
      if (!f_hs && prev && fall1 < 0) fall1 = e;
      prev = f_hs;
      if (f_vs !== 1'b0 || f_su !== 1'b0) bad = 1'b1;
      if (e == 1) begin
        checks++;
        if (f_x !== 10'd1 || f_vis !== 1'b1) begin
          errors++;
          $display("FAIL h_edge1 x=%0d vis=%b want x=1 vis=1", f_x, f_vis);
        end
      end
      if (e == 799) begin
        checks++;
        if (f_x !== 10'd799 || f_vis !== 1'b1) begin
          errors++;
          $display("FAIL h_edge799 x=%0d vis=%b want x=799 vis=1", f_x, f_vis);
        end
      end
      if (e == 800) begin
        checks++;
        if (f_x !== 10'd0 || f_vis !== 1'b0) begin
          errors++;
          $display("FAIL h_edge800 x=%0d vis=%b want x=0 vis=0", f_x, f_vis);
        end
      end
      if (e == 1056) begin
        checks++;
        if (f_x !== 10'd0 || f_y !== 10'd1 || f_vis !== 1'b1) begin
          errors++;
          $display("FAIL h_line_wrap x=%0d y=%0d vis=%b want x=0 y=1 vis=1",
                   f_x, f_y, f_vis);
        end
      end
      if (e == 1057) begin
        checks++;
        if (f_x !== 10'd1 || f_y !== 10'd1) begin
          errors++;
          $display("FAIL h_line2_px1 x=%0d y=%0d want x=1 y=1", f_x, f_y);
        end
      end
    end
    checks++;
    if (rise1 != 840 || fall1 != 968) begin
      errors++;
      $display("FAIL hsync_window rise=%0d fall=%0d want 840 968", rise1, fall1);
    end
    checks++;
    if (rise2 != 1896) begin
      errors++;
      $display("FAIL hsync_period second_rise=%0d want 1896", rise2);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_no_vsync_su got activity want none in first two lines");
    end
  endtask

  task automatic test_small_frame;
    int pe [$];
    int pf [$];
    int want_e [4];
    int want_f [4];
    int vr, vf, hr, hf;
    logic pv, ph;
    want_e = '{24, 72, 120, 168};
    want_f = '{1, 2, 3, 0};
    vr = -1; vf = -1; hr = -1; hf = -1;
    pv = 1'b0; ph = 1'b0;
    rst_n = 1'b0;
    ce    = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (s_su) begin
        pe.push_back(e);
        pf.push_back(int'(s_fc));
      end
      if (s_vs && !pv && vr < 0) vr = e;
      if (!s_vs && pv && vf < 0) vf = e;
      if (s_hs && !ph && hr < 0) hr = e;
      if (!s_hs && ph && hf < 0) hf = e;
      pv = s_vs;
      ph = s_hs;
      if (e == 3) begin
        checks++;
        if (s_x !== 10'd3 || s_vis !== 1'b1) begin
          errors++;
          $display("FAIL small_last_vis x=%0d vis=%b want x=3 vis=1", s_x, s_vis);
        end
      end
      if (e == 4) begin
        checks++;
        if (s_x !== 10'd0 || s_vis !== 1'b0) begin
          errors++;
          $display("FAIL small_first_blank x=%0d vis=%b want x=0 vis=0", s_x, s_vis);
        end
      end
      if (e == 8) begin
        checks++;
        if (s_x !== 10'd0 || s_y !== 10'd1 || s_vis !== 1'b1) begin
          errors++;
          $display("FAIL small_line2 x=%0d y=%0d vis=%b want 0 1 1", s_x, s_y, s_vis);
        end
      end
    end
    checks++;
    if (hr != 5 || hf != 7) begin
      errors++;
      $display("FAIL small_hsync rise=%0d fall=%0d want 5 7", hr, hf);
    end
    checks++;
    if (vr != 32 || vf != 40) begin
      errors++;
      $display("FAIL small_vsync rise=%0d fall=%0d want 32 40", vr, vf);
    end
    checks++;
    if (pe.size() != 4) begin
      errors++;
      $display("FAIL su_count got=%0d want 4", pe.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pe[i] != want_e[i] || pf[i] != want_f[i]) begin
          errors++;
          $display("FAIL su_pulse%0d edge=%0d fc=%0d want edge=%0d fc=%0d",
                   i, pe[i], pf[i], want_e[i], want_f[i]);
        end
      end
    end
  endtask

  task automatic test_ce_toggle;
    int k, h, v, fc_e;
    logic vis_e, hs_e, vs_e, su_e;
    logic [9:0] x_e, y_e;
    rst_n = 1'b0;
    ce    = 1'b1;
    tick();
    rst_n = 1'b1;
    k = 0;
    for (int e = 1; e <= 220; e++) begin
      ce = e[0];
      tick();
      if (ce) k++;
      h     = k % 8;
      v     = (k / 8) % 6;
      vis_e = (h < 4) && (v < 3);
      x_e   = vis_e ? 10'(h) : 10'd0;
      y_e   = vis_e ? 10'(v) : 10'd0;
      hs_e  = (h >= 5) && (h < 7);
      vs_e  = (v == 4);
      su_e  = ce && (k % 48 == 24);
      fc_e  = (k < 24) ? 0 : (((k - 24) / 48 + 1) % 4);
      checks++;
      if (s_vis !== vis_e || s_x !== x_e || s_y !== y_e || s_hs !== hs_e
          || s_vs !== vs_e || s_su !== su_e || s_fc !== 2'(fc_e)) begin
        errors++;
        $display("FAIL ce_toggle e=%0d got vis=%b x=%0d y=%0d hs=%b vs=%b su=%b fc=%0d want %b %0d %0d %b %b %b %0d",
                 e, s_vis, s_x, s_y, s_hs, s_vs, s_su, s_fc,
                 vis_e, x_e, y_e, hs_e, vs_e, su_e, fc_e);
      end
    end
  endtask

  task automatic test_midframe_reset;
    int found;
    ce    = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({s_vis, s_hs, s_vs, s_su} !== 4'b1000 || s_x !== 10'd0
        || s_y !== 10'd0 || s_fc !== 2'd0) begin
      errors++;
      $display("FAIL midframe_reset vis=%b hs=%b vs=%b su=%b x=%0d y=%0d fc=%0d want 1 0 0 0 0 0 0",
               s_vis, s_hs, s_vs, s_su, s_x, s_y, s_fc);
    end
    rst_n = 1'b1;
    repeat (24) tick();
    checks++;
    if (s_su !== 1'b1 || s_fc !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_pulse su=%b fc=%0d want 1 1", s_su, s_fc);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (s_su !== 1'b0 || s_fc !== 2'd0 || s_vis !== 1'b1 || s_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_drops_pulse su=%b fc=%0d vis=%b y=%0d want 0 0 1 0",
               s_su, s_fc, s_vis, s_y);
    end
    rst_n = 1'b1;
    ce    = 1'b0;
    repeat (3) tick();
    checks++;
    if (s_x !== 10'd0 || s_vis !== 1'b1 || s_su !== 1'b0) begin
      errors++;
      $display("FAIL held_after_release x=%0d vis=%b su=%b want 0 1 0", s_x, s_vis, s_su);
    end
    ce = 1'b1;
    found = -1;
    for (int e = 1; e <= 100 && found < 0; e++) begin
      tick();
      if (s_su) found = e;
    end
    checks++;
    if (found != 24 || s_fc !== 2'd1) begin
      errors++;
      $display("FAIL restart_pulse edge=%0d fc=%0d want edge=24 fc=1", found, s_fc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    test_reset();
    test_hline();
    test_small_frame();
    test_ce_toggle();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
